// File: rtl/tamagotchi_pkg.sv
// Shared types for the pet attribute manager: activity codes, sequencer states, delta selects.
// sel_delta maps (latched activity, sequencer state) to the operation the shared adder applies.
package tamagotchi_pkg;

   localparam int STAT_W = 8;

   localparam logic [3:0] IDLE       = 4'b0000;
   localparam logic [3:0] DORMINDO   = 4'b0001;
   localparam logic [3:0] COMENDO    = 4'b0010;
   localparam logic [3:0] DANDO_AULA = 4'b0100;
   localparam logic [3:0] MORTO      = 4'b1000;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] U_FOME  = 2'd1;
   localparam logic [1:0] U_FELIC = 2'd2;
   localparam logic [1:0] U_SONO  = 2'd3;

   typedef enum logic [1:0] {
      INC  = 2'd0,
      DEC  = 2'd1,
      DEC2 = 2'd2,
      HOLD = 2'd3
   } delta_sel_t;

   // Unknown and multi-hot activity codes fall back to IDLE behaviour.
   function automatic delta_sel_t sel_delta(input logic [3:0] est, input logic [1:0] st);
      delta_sel_t d;
      d = DEC;
      case (est)
         MORTO:      d = HOLD;
         COMENDO:    d = (st == U_FOME)  ? INC : DEC;
         DORMINDO:   d = (st == U_SONO)  ? INC : DEC;
         DANDO_AULA: d = (st == U_FELIC) ? INC : ((st == U_SONO) ? DEC2 : DEC);
         default:    d = DEC;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/gerenciador_atributos_if.sv
// Attribute bus: activity code in, the three attributes plus tick/busy/morto status out.
// master = attribute manager (sole writer), slave = state controller / display readers.
interface gerenciador_atributos_if;
   import tamagotchi_pkg::*;

   logic [3:0]        estado;
   logic [STAT_W-1:0] fome;
   logic [STAT_W-1:0] felicidade;
   logic [STAT_W-1:0] sono;
   logic              tick;
   logic              busy;
   logic              morto;

   modport master (
      input  estado,
      output fome, felicidade, sono, tick, busy, morto
   );

   modport slave (
      output estado,
      input  fome, felicidade, sono, tick, busy, morto
   );

endinterface

// File: rtl/satura_somador.sv
// Combinational saturating add/sub: 9-bit internal arithmetic, clamps to [0, stat_max].
// No state, no latency; shared by the three attribute update slots.
module satura_somador
   import tamagotchi_pkg::*;
(
   input  logic [STAT_W-1:0] value,
   input  delta_sel_t        sel,
   input  logic [STAT_W-1:0] gain,
   input  logic [STAT_W-1:0] decay,
   input  logic [STAT_W-1:0] stat_max,
   output logic [STAT_W-1:0] result
);

   logic [STAT_W:0] v9;
   logic [STAT_W:0] amt9;
   logic [STAT_W:0] sum9;
   logic [STAT_W:0] max9;

   always_comb begin
      v9     = {1'b0, value};
      max9   = {1'b0, stat_max};
      amt9   = '0;
      sum9   = v9;
      result = value;
      case (sel)
         INC: begin
            sum9   = v9 + {1'b0, gain};
            result = (sum9 > max9) ? stat_max : sum9[STAT_W-1:0];
         end
         DEC, DEC2: begin
            amt9 = (sel == DEC2) ? {decay, 1'b0} : {1'b0, decay};
            sum9 = v9 - amt9;
            // Borrow means the attribute is depleted; never let it wrap to a high value.
            if (v9 < amt9)
               result = '0;
            else if (sum9 > max9)
               result = stat_max;
            else
               result = sum9[STAT_W-1:0];
         end
         default: result = value;
      endcase
   end

endmodule

// File: rtl/gerenciador_atributos.sv
// Pet attribute manager: per game tick, one shared saturating adder updates fome, felicidade, sono in turn.
// All three final 3 cycles after tick; MORTE_EN adds a sticky death flag that freezes attributes.
module gerenciador_atributos
   import tamagotchi_pkg::*;
#(
   parameter int                TICK_DIV  = 50_000_000,
   parameter logic [STAT_W-1:0] DECAY     = 8'd1,
   parameter logic [STAT_W-1:0] GAIN      = 8'd4,
   parameter logic [STAT_W-1:0] STAT_MAX  = 8'd255,
   parameter logic [STAT_W-1:0] STAT_INIT = 8'd128
)
(
   input  logic                     clk,
   input  logic                     rst,
   gerenciador_atributos_if.master  bus
);

   localparam int CNT_W = $clog2(TICK_DIV);

   if (TICK_DIV < 8) begin : g_bad_tick_div
      $error("gerenciador_atributos: TICK_DIV must be >= 8");
   end

   logic [CNT_W-1:0]  cnt;
   logic              wrap;
   logic              tick_q;
   logic [1:0]        state;
   logic [3:0]        estado_q;
   logic [STAT_W-1:0] fome_q;
   logic [STAT_W-1:0] felic_q;
   logic [STAT_W-1:0] sono_q;
   logic [STAT_W-1:0] cur_val;
   logic [STAT_W-1:0] res;
   delta_sel_t        sel;
   logic              wr_en;

   assign wrap = (cnt == CNT_W'(TICK_DIV - 1));

   always_comb begin
      cur_val = sono_q;
      case (state)
         U_FOME:  cur_val = fome_q;
         U_FELIC: cur_val = felic_q;
         default: cur_val = sono_q;
      endcase
   end

   assign sel = sel_delta(estado_q, state);

   satura_somador u_somador (
      .value    (cur_val),
      .sel      (sel),
      .gain     (GAIN),
      .decay    (DECAY),
      .stat_max (STAT_MAX),
      .result   (res)
   );

`ifdef MORTE_EN
   logic morto_q;

   // Checked on the U_SONO edge using the post-write sono value so the flag lands one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         morto_q <= 1'b0;
      else if (state == U_SONO && (fome_q == '0 || felic_q == '0 || res == '0))
         morto_q <= 1'b1;
   end

   assign wr_en     = ~morto_q;
   assign bus.morto = morto_q;
`else
   assign wr_en     = 1'b1;
   assign bus.morto = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         tick_q   <= 1'b0;
         state    <= S_IDLE;
         estado_q <= IDLE;
         fome_q   <= STAT_INIT;
         felic_q  <= STAT_INIT;
         sono_q   <= STAT_INIT;
      end else begin
         cnt    <= wrap ? '0 : cnt + CNT_W'(1);
         tick_q <= wrap;

         // A wrap seen mid-sequence is ignored, and estado_q stays frozen for the sequence in flight.
         case (state)
            S_IDLE: begin
               if (wrap) begin
                  state    <= U_FOME;
                  estado_q <= bus.estado;
               end
            end
            U_FOME:  state <= U_FELIC;
            U_FELIC: state <= U_SONO;
            default: state <= S_IDLE;
         endcase

         if (wr_en) begin
            case (state)
               U_FOME:  fome_q  <= res;
               U_FELIC: felic_q <= res;
               U_SONO:  sono_q  <= res;
               default: ;
            endcase
         end
      end
   end

   assign bus.fome       = fome_q;
   assign bus.felicidade = felic_q;
   assign bus.sono       = sono_q;
   assign bus.tick       = tick_q;
   assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Directed bench for gerenciador_atributos with TICK_DIV=8; expectations adapt to the MORTE_EN build option.
module tb_gerenciador_atributos;
   import tamagotchi_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic prev_busy;

   gerenciador_atributos_if bus_if ();

   gerenciador_atributos #(
      .TICK_DIV  (8),
      .DECAY     (8'd1),
      .GAIN      (8'd4),
      .STAT_MAX  (8'd255),
      .STAT_INIT (8'd128)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_attrs(input string tag, input int f, input int h, input int s);
      check({tag, ".fome"}, int'(bus_if.fome), f);
      check({tag, ".felicidade"}, int'(bus_if.felicidade), h);
      check({tag, ".sono"}, int'(bus_if.sono), s);
   endtask

   // Returns at the negedge where tick is seen; cycles = posedges elapsed since call.
   task automatic wait_tick(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (bus_if.tick !== 1'b1 && cycles < 20);
      if (bus_if.tick !== 1'b1) begin
         total++;
         bad++;
         $error("FAIL tick_timeout: observed=no tick expected=tick within 20 cycles");
      end
   endtask

   task automatic run_ticks(input int n);
      int c;
      for (int i = 0; i < n; i++) begin
         wait_tick(c);
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic do_reset(input logic [3:0] est);
      bus_if.estado = est;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // A tick must never arrive while a sequence is already in flight.
   always @(negedge clk) begin
      if (rst) begin
         prev_busy = 1'b0;
      end else begin
         if (bus_if.tick === 1'b1)
            check("tick_while_busy", int'(prev_busy), 0);
         prev_busy = bus_if.busy;
      end
   end

   initial begin
      int c;
      int b;
      int morto_exp;
      total = 0;
      bad = 0;
      prev_busy = 1'b0;
      rst = 1'b1;
      bus_if.estado = IDLE;

`ifdef MORTE_EN
      morto_exp = 1;
`else
      morto_exp = 0;
`endif

      // 1. reset state, first tick latency, busy width, IDLE decay
      repeat (2) @(negedge clk);
      check_attrs("reset", 128, 128, 128);
      check("reset.tick", int'(bus_if.tick), 0);
      check("reset.busy", int'(bus_if.busy), 0);
      check("reset.morto", int'(bus_if.morto), 0);
      rst = 1'b0;
      wait_tick(c);
      check("first_tick_cycle", c, 8);
      b = 0;
      while (bus_if.busy === 1'b1 && b < 10) begin
         b++;
         @(negedge clk);
      end
      check("busy_width", b, 3);
      check_attrs("idle_tick", 127, 127, 127);

      // 2. COMENDO gain, then saturation at 255
      do_reset(COMENDO);
      run_ticks(2);
      check_attrs("comendo_x2", 136, 126, 126);
      do_reset(IDLE);
      run_ticks(3);
      check_attrs("idle_x3", 125, 125, 125);
      bus_if.estado = COMENDO;
      run_ticks(32);
      check_attrs("comendo_to_253", 253, 93, 93);
      run_ticks(1);
      check_attrs("comendo_sat", 255, 92, 92);
      run_ticks(1);
      check_attrs("comendo_sat2", 255, 91, 91);

      // 4. estado change after tick does not disturb the in-flight sequence
      do_reset(IDLE);
      wait_tick(c);
      @(negedge clk);
      bus_if.estado = DORMINDO;
      repeat (2) @(negedge clk);
      check_attrs("inflight_idle", 127, 127, 127);
      run_ticks(1);
      check_attrs("next_dormindo", 126, 126, 131);

      // 6. reset pulsed during U_FELIC
      do_reset(IDLE);
      wait_tick(c);
      @(negedge clk);
      check("mid_seq.fome_written", int'(bus_if.fome), 127);
      rst = 1'b1;
      #1;
      check_attrs("mid_rst", 128, 128, 128);
      check("mid_rst.busy", int'(bus_if.busy), 0);
      check("mid_rst.tick", int'(bus_if.tick), 0);
      @(negedge clk);
      rst = 1'b0;
      wait_tick(c);
      check("tick_after_mid_rst", c, 8);
      repeat (3) @(negedge clk);
      check_attrs("after_mid_rst", 127, 127, 127);

      // 3 + 5. drive everything to 1, DANDO_AULA clamps sono to 0, then death/freeze or recovery
      do_reset(IDLE);
      run_ticks(127);
      check_attrs("idle_x127", 1, 1, 1);
      check("pre_death.morto", int'(bus_if.morto), 0);
      bus_if.estado = DANDO_AULA;
      wait_tick(c);
      repeat (2) @(negedge clk);
      check("u_sono.busy", int'(bus_if.busy), 1);
      check("u_sono.morto", int'(bus_if.morto), 0);
      @(negedge clk);
      check_attrs("aula_clamp", 0, 5, 0);
      check("after_u_sono.morto", int'(bus_if.morto), morto_exp);
      bus_if.estado = COMENDO;
      run_ticks(2);
`ifdef MORTE_EN
      check_attrs("frozen", 0, 5, 0);
`else
      check_attrs("recover", 8, 3, 0);
`endif
      check("final.morto", int'(bus_if.morto), morto_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
